coin_collector: RTL and testbench

Front-end sequencer for the vending machine: accepts product-selection buttons and single-cycle coin pulses (1, 2, 5 units), keeps per-denomination coin counts, and drives the product/command code and coin counts consumed directly by the downstream change-calculation stage. It decides when a purchase is funded, issues buy or refund commands, enforces count and total limits so the downstream 4-bit change arithmetic never overflows, and refunds automatically on inactivity.

---
 rtl/coin_collector.sv | 205 ++++++++++++++++++++
 tb/tb_coin_collector.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_collector.sv
// coin_collector
// Front-end sequencer for the vending machine. Takes product-select and coin
// pulses, keeps per-denomination coin counts, and presents the product code
// (op1), the command (op2) and the coin counts to the change-calculation stage.
// It also caps counts and totals so the downstream 4-bit change arithmetic
// cannot overflow, and refunds automatically after a period of inactivity.
//
// Handshake: there is none. Every input is a single-cycle pulse sampled on
// the rising edge, and every output is a register that changes only after that
// edge. The change stage must read op1/op2/counts while op2 is nonzero; they
// are held stable for HOLD_CYCLES cycles.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   sel_a, sel_b               product-select pulses (both at once is ignored)
//   coin1, coin2, coin5        coin-inserted pulses
//   buy, cancel                purchase confirm / refund request
//   op1[1:0]                   product code: 00 none, 01 A, 10 B
//   op2[1:0]                   command: 00 none, 01 vend, 10 refund
//   i1, i2, i5[3:0]            accepted coin counts
//   total[6:0]                 i1 + 2*i2 + 5*i5
//   reject                     one-cycle pulse: a coin in the previous cycle was refused
//   short                      one-cycle pulse: buy refused for insufficient funds
//   busy                       high while vending or refunding
module coin_collector #(
  parameter int PRICE_A        = 7,
  parameter int PRICE_B        = 9,
  parameter int HOLD_CYCLES    = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sel_a,
  input  logic       sel_b,
  input  logic       coin1,
  input  logic       coin2,
  input  logic       coin5,
  input  logic       buy,
  input  logic       cancel,
  output logic [1:0] op1,
  output logic [1:0] op2,
  output logic [3:0] i1,
  output logic [3:0] i2,
  output logic [3:0] i5,
  output logic [6:0] total,
  output logic       reject,
  output logic       short,
  output logic       busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, VEND, REFUND} state_t;

  state_t        state, state_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [HW-1:0] hcnt, hcnt_n;
  logic [1:0]    op1_n, op2_n;
  logic [3:0]    i1_n, i2_n, i5_n;
  logic [6:0]    total_n;
  logic          reject_n, short_n, busy_n;

  logic          sel_one, any_coin, funded;
  logic          acc1, acc2, acc5, rej;
  logic [7:0]    price, limit, run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      tcnt   <= '0;
      hcnt   <= '0;
      op1    <= 2'b00;
      op2    <= 2'b00;
      i1     <= 4'd0;
      i2     <= 4'd0;
      i5     <= 4'd0;
      total  <= 7'd0;
      reject <= 1'b0;
      short  <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_n;
      tcnt   <= tcnt_n;
      hcnt   <= hcnt_n;
      op1    <= op1_n;
      op2    <= op2_n;
      i1     <= i1_n;
      i2     <= i2_n;
      i5     <= i5_n;
      total  <= total_n;
      reject <= reject_n;
      short  <= short_n;
      busy   <= busy_n;
    end
  end

  always_comb begin
    state_n  = state;
    tcnt_n   = tcnt;
    hcnt_n   = hcnt;
    op1_n    = op1;
    op2_n    = op2;
    i1_n     = i1;
    i2_n     = i2;
    i5_n     = i5;
    reject_n = 1'b0;
    short_n  = 1'b0;
    acc1     = 1'b0;
    acc2     = 1'b0;
    acc5     = 1'b0;
    rej      = 1'b0;
    sel_one  = sel_a ^ sel_b;
    any_coin = coin1 | coin2 | coin5;
    price    = (op1 == 2'b01) ? 8'(PRICE_A) : (op1 == 2'b10) ? 8'(PRICE_B) : 8'd0;
    limit    = price + 8'd15;
    run      = {1'b0, total};
    funded   = (run >= price) && (run <= limit);

    case (state)
      IDLE: begin
        reject_n = any_coin;
        if (sel_one) begin
          op1_n   = sel_a ? 2'b01 : 2'b10;
          tcnt_n  = '0;
          state_n = COLLECT;
        end
      end

      COLLECT: begin
        // Leaving for VEND/REFUND freezes the counts, so any coin arriving in
        // the same cycle is refused rather than silently added.
        if (cancel) begin
          state_n  = REFUND;
          op2_n    = 2'b10;
          hcnt_n   = '0;
          reject_n = any_coin;
        end else if (buy && funded) begin
          state_n  = VEND;
          op2_n    = 2'b01;
          hcnt_n   = '0;
          reject_n = any_coin;
        end else begin
          // Largest coin first, each checked against the running total so a
          // later smaller coin can still fit after a larger one is refused.
          if (coin5) begin
            if (i5 != 4'd15 && run + 8'd5 <= limit) begin
              acc5 = 1'b1;
              run  = run + 8'd5;
            end else rej = 1'b1;
          end
          if (coin2) begin
            if (i2 != 4'd15 && run + 8'd2 <= limit) begin
              acc2 = 1'b1;
              run  = run + 8'd2;
            end else rej = 1'b1;
          end
          if (coin1) begin
            if (i1 != 4'd15 && run + 8'd1 <= limit) begin
              acc1 = 1'b1;
              run  = run + 8'd1;
            end else rej = 1'b1;
          end
          reject_n = rej;
          short_n  = buy;
          if (acc5) i5_n = i5 + 4'd1;
          if (acc2) i2_n = i2 + 4'd1;
          if (acc1) i1_n = i1 + 4'd1;
          // Re-selecting keeps the coins already held, even past the new limit.
          if (sel_one) op1_n = sel_a ? 2'b01 : 2'b10;
          if (acc1 || acc2 || acc5 || sel_one || buy) begin
            tcnt_n = '0;
          end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            state_n = REFUND;
            op2_n   = 2'b10;
            hcnt_n  = '0;
          end else begin
            tcnt_n = tcnt + TW'(1);
          end
        end
      end

      VEND, REFUND: begin
        reject_n = any_coin;
        if (hcnt == HW'(HOLD_CYCLES - 1)) begin
          state_n = IDLE;
          hcnt_n  = '0;
          op1_n   = 2'b00;
          op2_n   = 2'b00;
          i1_n    = 4'd0;
          i2_n    = 4'd0;
          i5_n    = 4'd0;
        end else begin
          hcnt_n = hcnt + HW'(1);
        end
      end

      default: state_n = IDLE;
    endcase

    total_n = {3'b000, i1_n} + {2'b00, i2_n, 1'b0} + {3'b000, i5_n} + {1'b0, i5_n, 2'b00};
    busy_n  = (state_n == VEND) || (state_n == REFUND);
  end

endmodule

// File: tb/tb_coin_collector.sv
// tb_coin_collector
// Self-checking bench for coin_collector with default parameters
// (PRICE_A=7, PRICE_B=9, HOLD_CYCLES=4, TIMEOUT_CYCLES=255).
// Each scenario task builds a table of stimulus and hand-derived expected
// outputs; the expected word is queued as each stimulus is driven and popped
// for comparison after the clock edge that produces the response.
// Expected word layout: {op1, op2, i1, i2, i5, total, reject, short, busy}.
module tb_coin_collector;

  localparam logic [6:0] NONE = 7'b0000000;
  localparam logic [6:0] S_A  = 7'b1000000;
  localparam logic [6:0] S_B  = 7'b0100000;
  localparam logic [6:0] C1   = 7'b0010000;
  localparam logic [6:0] C2   = 7'b0001000;
  localparam logic [6:0] C5   = 7'b0000100;
  localparam logic [6:0] BY   = 7'b0000010;
  localparam logic [6:0] CN   = 7'b0000001;

  logic       clk, rst_n;
  logic       sel_a, sel_b, coin1, coin2, coin5, buy, cancel;
  logic [1:0] op1, op2;
  logic [3:0] i1, i2, i5;
  logic [6:0] total;
  logic       reject, short, busy;
  logic [25:0] obs;

  logic [25:0] exp_q[$];
  logic [6:0]  st_tab[$];
  logic [25:0] ex_tab[$];
  int n_tests = 0;
  int n_fail  = 0;

  coin_collector dut (
    .clk(clk), .rst_n(rst_n),
    .sel_a(sel_a), .sel_b(sel_b),
    .coin1(coin1), .coin2(coin2), .coin5(coin5),
    .buy(buy), .cancel(cancel),
    .op1(op1), .op2(op2), .i1(i1), .i2(i2), .i5(i5),
    .total(total), .reject(reject), .short(short), .busy(busy)
  );

  assign obs = {op1, op2, i1, i2, i5, total, reject, short, busy};

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [25:0] pk(input logic [1:0] o1, input logic [1:0] o2,
                                     input logic [3:0] n1, input logic [3:0] n2,
                                     input logic [3:0] n5, input logic [6:0] t,
                                     input logic r, input logic s, input logic b);
    return {o1, o2, n1, n2, n5, t, r, s, b};
  endfunction

  // driver: apply one cycle of inputs, then sample 1 time unit after the edge
  task automatic tick(input logic [6:0] s);
    {sel_a, sel_b, coin1, coin2, coin5, buy, cancel} = s;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [6:0] s, input logic [25:0] e);
    st_tab.push_back(s);
    ex_tab.push_back(e);
  endtask

  task automatic test_reset();
    logic [25:0] want;
    rst_n = 1'b0;
    {sel_a, sel_b, coin1, coin2, coin5, buy, cancel} = 7'b1111111;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(26'd0);
    want = exp_q.pop_front();
    n_tests++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL reset: got 0x%07h expected 0x%07h", obs, want);
    end
    {sel_a, sel_b, coin1, coin2, coin5, buy, cancel} = NONE;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_idle();
    logic [25:0] want;
    st_tab.delete(); ex_tab.delete();
    add(C5,        pk(2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 0));
    add(C1 | C2,   pk(2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 0));
    add(S_A | S_B, pk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    add(BY,        pk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    add(CN,        pk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < st_tab.size(); k++) begin
      exp_q.push_back(ex_tab[k]);
      tick(st_tab[k]);
      want = exp_q.pop_front();
      n_tests++;
      if (obs !== want) begin
        n_fail++;
        $display("FAIL idle step %0d: got 0x%07h expected 0x%07h", k, obs, want);
      end
    end
  endtask

  task automatic test_buy_a();
    logic [25:0] want;
    st_tab.delete(); ex_tab.delete();
    add(S_A,  pk(2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    add(C5,   pk(2'b01, 2'b00, 0, 0, 1, 5, 0, 0, 0));
    add(C2,   pk(2'b01, 2'b00, 0, 1, 1, 7, 0, 0, 0));
    add(BY,   pk(2'b01, 2'b01, 0, 1, 1, 7, 0, 0, 1));
    add(C1,   pk(2'b01, 2'b01, 0, 1, 1, 7, 1, 0, 1));
    add(S_B,  pk(2'b01, 2'b01, 0, 1, 1, 7, 0, 0, 1));
    add(CN,   pk(2'b01, 2'b01, 0, 1, 1, 7, 0, 0, 1));
    add(NONE, pk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < st_tab.size(); k++) begin
      exp_q.push_back(ex_tab[k]);
      tick(st_tab[k]);
      want = exp_q.pop_front();
      n_tests++;
      if (obs !== want) begin
        n_fail++;
        $display("FAIL buy_a step %0d: got 0x%07h expected 0x%07h", k, obs, want);
      end
    end
  endtask

  task automatic test_short();
    logic [25:0] want;
    st_tab.delete(); ex_tab.delete();
    add(S_B,  pk(2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    add(C5,   pk(2'b10, 2'b00, 0, 0, 1, 5, 0, 0, 0));
    add(BY,   pk(2'b10, 2'b00, 0, 0, 1, 5, 0, 1, 0));
    add(NONE, pk(2'b10, 2'b00, 0, 0, 1, 5, 0, 0, 0));
    add(C5,   pk(2'b10, 2'b00, 0, 0, 2, 10, 0, 0, 0));
    add(BY,   pk(2'b10, 2'b01, 0, 0, 2, 10, 0, 0, 1));
    for (int k = 0; k < 3; k++) add(NONE, pk(2'b10, 2'b01, 0, 0, 2, 10, 0, 0, 1));
    add(NONE, pk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < st_tab.size(); k++) begin
      exp_q.push_back(ex_tab[k]);
      tick(st_tab[k]);
      want = exp_q.pop_front();
      n_tests++;
      if (obs !== want) begin
        n_fail++;
        $display("FAIL short step %0d: got 0x%07h expected 0x%07h", k, obs, want);
      end
    end
  endtask

  task automatic test_limits();
    logic [25:0] want;
    st_tab.delete(); ex_tab.delete();
    add(S_A, pk(2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 15; k++) add(C1, pk(2'b01, 2'b00, 4'(k), 0, 0, 7'(k), 0, 0, 0));
    add(C1, pk(2'b01, 2'b00, 15, 0, 0, 15, 1, 0, 0));
    add(C5, pk(2'b01, 2'b00, 15, 0, 1, 20, 0, 0, 0));
    add(C5, pk(2'b01, 2'b00, 15, 0, 1, 20, 1, 0, 0));
    add(CN, pk(2'b01, 2'b10, 15, 0, 1, 20, 0, 0, 1));
    for (int k = 0; k < 3; k++) add(NONE, pk(2'b01, 2'b10, 15, 0, 1, 20, 0, 0, 1));
    add(NONE, pk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < st_tab.size(); k++) begin
      exp_q.push_back(ex_tab[k]);
      tick(st_tab[k]);
      want = exp_q.pop_front();
      n_tests++;
      if (obs !== want) begin
        n_fail++;
        $display("FAIL limits step %0d: got 0x%07h expected 0x%07h", k, obs, want);
      end
    end
  endtask

  task automatic test_multi_cancel();
    logic [25:0] want;
    st_tab.delete(); ex_tab.delete();
    add(S_A,           pk(2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    add(C1 | C2 | C5,  pk(2'b01, 2'b00, 1, 1, 1, 8, 0, 0, 0));
    add(BY | CN,       pk(2'b01, 2'b10, 1, 1, 1, 8, 0, 0, 1));
    for (int k = 0; k < 3; k++) add(NONE, pk(2'b01, 2'b10, 1, 1, 1, 8, 0, 0, 1));
    add(NONE,          pk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < st_tab.size(); k++) begin
      exp_q.push_back(ex_tab[k]);
      tick(st_tab[k]);
      want = exp_q.pop_front();
      n_tests++;
      if (obs !== want) begin
        n_fail++;
        $display("FAIL multi_cancel step %0d: got 0x%07h expected 0x%07h", k, obs, want);
      end
    end
  endtask

  task automatic test_reselect();
    logic [25:0] want;
    st_tab.delete(); ex_tab.delete();
    // re-select to B with 15 held: funded, vend as B
    add(S_A, pk(2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 3; k++) add(C5, pk(2'b01, 2'b00, 0, 0, 4'(k), 7'(5 * k), 0, 0, 0));
    add(S_B, pk(2'b10, 2'b00, 0, 0, 3, 15, 0, 0, 0));
    add(BY,  pk(2'b10, 2'b01, 0, 0, 3, 15, 0, 0, 1));
    for (int k = 0; k < 3; k++) add(NONE, pk(2'b10, 2'b01, 0, 0, 3, 15, 0, 0, 1));
    add(NONE, pk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    // fill B to its ceiling of 24, re-select A (over 22): buy short; back to B: exact ceiling vends
    add(S_B, pk(2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 4; k++) add(C5, pk(2'b10, 2'b00, 0, 0, 4'(k), 7'(5 * k), 0, 0, 0));
    add(C2,  pk(2'b10, 2'b00, 0, 1, 4, 22, 0, 0, 0));
    add(C2,  pk(2'b10, 2'b00, 0, 2, 4, 24, 0, 0, 0));
    add(C2,  pk(2'b10, 2'b00, 0, 2, 4, 24, 1, 0, 0));
    add(S_A, pk(2'b01, 2'b00, 0, 2, 4, 24, 0, 0, 0));
    add(BY,  pk(2'b01, 2'b00, 0, 2, 4, 24, 0, 1, 0));
    add(S_B, pk(2'b10, 2'b00, 0, 2, 4, 24, 0, 0, 0));
    add(BY,  pk(2'b10, 2'b01, 0, 2, 4, 24, 0, 0, 1));
    for (int k = 0; k < 3; k++) add(NONE, pk(2'b10, 2'b01, 0, 2, 4, 24, 0, 0, 1));
    add(NONE, pk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < st_tab.size(); k++) begin
      exp_q.push_back(ex_tab[k]);
      tick(st_tab[k]);
      want = exp_q.pop_front();
      n_tests++;
      if (obs !== want) begin
        n_fail++;
        $display("FAIL reselect step %0d: got 0x%07h expected 0x%07h", k, obs, want);
      end
    end
  endtask

  task automatic test_timeout();
    logic [25:0] want;
    st_tab.delete(); ex_tab.delete();
    add(S_B, pk(2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    add(C2,  pk(2'b10, 2'b00, 0, 1, 0, 2, 0, 0, 0));
    for (int k = 1; k <= 254; k++) add(NONE, pk(2'b10, 2'b00, 0, 1, 0, 2, 0, 0, 0));
    add(NONE, pk(2'b10, 2'b10, 0, 1, 0, 2, 0, 0, 1));
    for (int k = 0; k < 3; k++) add(NONE, pk(2'b10, 2'b10, 0, 1, 0, 2, 0, 0, 1));
    add(NONE, pk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < st_tab.size(); k++) begin
      exp_q.push_back(ex_tab[k]);
      tick(st_tab[k]);
      want = exp_q.pop_front();
      n_tests++;
      if (obs !== want) begin
        n_fail++;
        $display("FAIL timeout step %0d: got 0x%07h expected 0x%07h", k, obs, want);
      end
    end
  endtask

  task automatic test_reset_mid_vend();
    logic [25:0] want;
    st_tab.delete(); ex_tab.delete();
    add(S_A,  pk(2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    add(C5,   pk(2'b01, 2'b00, 0, 0, 1, 5, 0, 0, 0));
    add(C2,   pk(2'b01, 2'b00, 0, 1, 1, 7, 0, 0, 0));
    add(BY,   pk(2'b01, 2'b01, 0, 1, 1, 7, 0, 0, 1));
    add(NONE, pk(2'b01, 2'b01, 0, 1, 1, 7, 0, 0, 1));
    for (int k = 0; k < st_tab.size(); k++) begin
      exp_q.push_back(ex_tab[k]);
      tick(st_tab[k]);
      want = exp_q.pop_front();
      n_tests++;
      if (obs !== want) begin
        n_fail++;
        $display("FAIL reset_mid step %0d: got 0x%07h expected 0x%07h", k, obs, want);
      end
    end
    // asynchronous assert between edges: outputs clear without a clock edge
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.push_back(26'd0);
    want = exp_q.pop_front();
    n_tests++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL reset_mid async: got 0x%07h expected 0x%07h", obs, want);
    end
    @(negedge clk);
    rst_n = 1'b1;
    st_tab.delete(); ex_tab.delete();
    add(C1,   pk(2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 0));
    add(NONE, pk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < st_tab.size(); k++) begin
      exp_q.push_back(ex_tab[k]);
      tick(st_tab[k]);
      want = exp_q.pop_front();
      n_tests++;
      if (obs !== want) begin
        n_fail++;
        $display("FAIL after_reset step %0d: got 0x%07h expected 0x%07h", k, obs, want);
      end
    end
  endtask

  initial begin
    {sel_a, sel_b, coin1, coin2, coin5, buy, cancel} = NONE;
    rst_n = 1'b0;
    test_reset();
    test_idle();
    test_buy_a();
    test_short();
    test_limits();
    test_multi_cancel();
    test_reselect();
    test_timeout();
    test_reset_mid_vend();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
